// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV32 pipeline memory stage.
package riscv_pkg;

  localparam int D_WIDTH_DEF = 32;
  localparam int REG_AW_DEF  = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic [1:0]             result_src;
    logic                   mem_write;
    logic [D_WIDTH_DEF-1:0] alu_result;
    logic [D_WIDTH_DEF-1:0] write_data;
    logic [REG_AW_DEF-1:0]  rd;
    logic [D_WIDTH_DEF-1:0] pc_plus_4;
  } ex_mem_t;

  function automatic logic is_mem_op(logic valid, logic [1:0] src, logic mem_write);
    return valid & ((src == RES_MEM) | mem_write);
  endfunction

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory handshake sequencer: request/response tracking, stall and completion pulse.
//   state | meaning
//   IDLE  | no access pending; slot completes immediately
//   REQ   | request driven, waiting for gnt
//   RESP  | load granted, waiting for rvalid
module dmem_req_fsm
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_load_i,
  input  logic gnt_i,
  input  logic rvalid_i,
  output logic req_o,
  output logic stall_o,
  output logic done_o,
  output logic load_done_o
);

  mem_state_t state_q, state_d;

  always_comb begin
    state_d     = state_q;
    req_o       = 1'b0;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    load_done_o = 1'b0;
    case (state_q)
      IDLE: done_o = 1'b1;
      REQ: begin
        req_o = 1'b1;
        if (gnt_i && !is_load_i) begin
          done_o = 1'b1;
        end else if (gnt_i) begin
          stall_o = 1'b1;
          state_d = RESP;
        end else begin
          stall_o = 1'b1;
        end
      end
      RESP: begin
        if (rvalid_i) begin
          done_o      = 1'b1;
          load_done_o = 1'b1;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Whenever the slot frees up, the instruction captured on this edge decides the next state.
    if (!stall_o) state_d = start_i ? REQ : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM + MEM/WB registers of the RV32 pipeline with word load/store handshake.
// Build option MEM_MISALIGN_TRAP_EN: misaligned memory ops are dropped and flagged on misalign_o/misalign_addr_o.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int REG_AW  = REG_AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_e_i,
  input  logic               reg_write_e_i,
  input  logic [1:0]         result_src_e_i,
  input  logic               mem_write_e_i,
  input  logic [D_WIDTH-1:0] alu_result_e_i,
  input  logic [D_WIDTH-1:0] write_data_e_i,
  input  logic [REG_AW-1:0]  rd_e_i,
  input  logic [D_WIDTH-1:0] pc_plus_4e_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [D_WIDTH-1:0] dmem_addr_o,
  output logic [D_WIDTH-1:0] dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [D_WIDTH-1:0] dmem_rdata_i,
  output logic               fwd_reg_write_m_o,
  output logic [REG_AW-1:0]  fwd_rd_m_o,
  output logic [D_WIDTH-1:0] fwd_alu_result_m_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic               misalign_o,
  output logic [D_WIDTH-1:0] misalign_addr_o,
`endif
  output logic               valid_w_o,
  output logic               reg_write_w_o,
  output logic [1:0]         result_src_w_o,
  output logic [D_WIDTH-1:0] alu_result_w_o,
  output logic [D_WIDTH-1:0] read_data_w_o,
  output logic [D_WIDTH-1:0] pc_plus_4w_o,
  output logic [REG_AW-1:0]  rd_w_o
);

  ex_mem_t ex_q, ex_d;
  logic start, misal_now, done, load_done, complete;
  logic e_mem_op;

  logic               valid_w_q, valid_w_d;
  logic               reg_write_w_q, reg_write_w_d;
  logic [1:0]         result_src_w_q, result_src_w_d;
  logic [D_WIDTH-1:0] alu_result_w_q, alu_result_w_d;
  logic [D_WIDTH-1:0] read_data_w_q, read_data_w_d;
  logic [D_WIDTH-1:0] pc_plus_4w_q, pc_plus_4w_d;
  logic [REG_AW-1:0]  rd_w_q, rd_w_d;

  assign e_mem_op = is_mem_op(valid_e_i & ~flush_i, result_src_e_i, mem_write_e_i);

`ifdef MEM_MISALIGN_TRAP_EN
  logic               misalign_q, misalign_d;
  logic [D_WIDTH-1:0] misalign_addr_q, misalign_addr_d;

  assign start     = e_mem_op & (alu_result_e_i[1:0] == 2'b00);
  assign misal_now = is_mem_op(ex_q.valid, ex_q.result_src, ex_q.mem_write)
                   & (ex_q.alu_result[1:0] != 2'b00);

  always_comb begin
    misalign_d      = misalign_q;
    misalign_addr_d = misalign_addr_q;
    if (misal_now && !misalign_q) begin
      misalign_d      = 1'b1;
      misalign_addr_d = ex_q.alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
`else
  assign start     = e_mem_op;
  assign misal_now = 1'b0;
`endif

  dmem_req_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .is_load_i  (ex_q.result_src == RES_MEM),
    .gnt_i      (dmem_gnt_i),
    .rvalid_i   (dmem_rvalid_i),
    .req_o      (dmem_req_o),
    .stall_o    (stall_o),
    .done_o     (done),
    .load_done_o(load_done)
  );

  // A stalled slot holds its contents, so a late flush can never kill an in-flight access.
  always_comb begin
    ex_d = ex_q;
    if (!stall_o) begin
      ex_d.valid      = valid_e_i & ~flush_i;
      ex_d.reg_write  = reg_write_e_i;
      ex_d.result_src = result_src_e_i;
      ex_d.mem_write  = mem_write_e_i;
      ex_d.alu_result = alu_result_e_i;
      ex_d.write_data = write_data_e_i;
      ex_d.rd         = rd_e_i;
      ex_d.pc_plus_4  = pc_plus_4e_i;
    end
  end

  assign complete = ex_q.valid & done & ~misal_now;

  always_comb begin
    valid_w_d      = complete;
    reg_write_w_d  = complete & ex_q.reg_write & ~ex_q.mem_write;
    result_src_w_d = ex_q.result_src;
    alu_result_w_d = ex_q.alu_result;
    read_data_w_d  = load_done ? dmem_rdata_i : '0;
    pc_plus_4w_d   = ex_q.pc_plus_4;
    rd_w_d         = ex_q.rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= '0;
      valid_w_q      <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      pc_plus_4w_q   <= '0;
      rd_w_q         <= '0;
    end else begin
      ex_q           <= ex_d;
      valid_w_q      <= valid_w_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_plus_4w_q   <= pc_plus_4w_d;
      rd_w_q         <= rd_w_d;
    end
  end

  assign dmem_we_o    = ex_q.mem_write;
  assign dmem_addr_o  = ex_q.alu_result & {{(D_WIDTH-2){1'b1}}, 2'b00};
  assign dmem_wdata_o = ex_q.write_data;

  assign fwd_reg_write_m_o  = ex_q.valid & ex_q.reg_write & ~ex_q.mem_write
                            & (ex_q.result_src != RES_MEM);
  assign fwd_rd_m_o         = ex_q.rd;
  assign fwd_alu_result_m_o = ex_q.alu_result;

  assign valid_w_o      = valid_w_q;
  assign reg_write_w_o  = reg_write_w_q;
  assign result_src_w_o = result_src_w_q;
  assign alu_result_w_o = alu_result_w_q;
  assign read_data_w_o  = read_data_w_q;
  assign pc_plus_4w_o   = pc_plus_4w_q;
  assign rd_w_o         = rd_w_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: ALU, load, delayed store, flush and mid-access reset scenarios.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_e_i, reg_write_e_i, mem_write_e_i, flush_i;
  logic [1:0]  result_src_e_i;
  logic [31:0] alu_result_e_i, write_data_e_i, pc_plus_4e_i;
  logic [4:0]  rd_e_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        fwd_reg_write_m_o;
  logic [4:0]  fwd_rd_m_o;
  logic [31:0] fwd_alu_result_m_o;
  logic        valid_w_o, reg_write_w_o;
  logic [1:0]  result_src_w_o;
  logic [31:0] alu_result_w_o, read_data_w_o, pc_plus_4w_o;
  logic [4:0]  rd_w_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  int checks = 0;
  int failures = 0;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .valid_e_i(valid_e_i), .reg_write_e_i(reg_write_e_i), .result_src_e_i(result_src_e_i),
    .mem_write_e_i(mem_write_e_i), .alu_result_e_i(alu_result_e_i),
    .write_data_e_i(write_data_e_i), .rd_e_i(rd_e_i), .pc_plus_4e_i(pc_plus_4e_i),
    .flush_i(flush_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i),
    .fwd_reg_write_m_o(fwd_reg_write_m_o), .fwd_rd_m_o(fwd_rd_m_o),
    .fwd_alu_result_m_o(fwd_alu_result_m_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
`endif
    .valid_w_o(valid_w_o), .reg_write_w_o(reg_write_w_o), .result_src_w_o(result_src_w_o),
    .alu_result_w_o(alu_result_w_o), .read_data_w_o(read_data_w_o),
    .pc_plus_4w_o(pc_plus_4w_o), .rd_w_o(rd_w_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    valid_e_i = 0; reg_write_e_i = 0; result_src_e_i = 2'b00; mem_write_e_i = 0;
    alu_result_e_i = 32'hFFFF_FFF0; write_data_e_i = 32'h1111_1111; rd_e_i = 5'd31;
    pc_plus_4e_i = 0; flush_i = 0;
  endtask

  task automatic op_in(input logic [1:0] src, input logic we, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    valid_e_i = 1; result_src_e_i = src; mem_write_e_i = we; reg_write_e_i = rw;
    alu_result_e_i = addr; write_data_e_i = wd; rd_e_i = rd; pc_plus_4e_i = 32'h44;
  endtask

  initial begin
    rst_n = 1; idle_in();
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    #1 rst_n = 0;
    tick(); tick();
    chk("rst_valid_w", valid_w_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_alu_w", alu_result_w_o, 0);
    rst_n = 1;
    tick();

    // ALU op
    op_in(2'b00, 0, 1, 32'h1234, 0, 5'd5);
    #1 chk("alu_stall", stall_o, 0);
    tick(); idle_in(); #1;
    chk("alu_fwd_we", fwd_reg_write_m_o, 1);
    chk("alu_fwd_rd", fwd_rd_m_o, 5);
    chk("alu_fwd_res", fwd_alu_result_m_o, 32'h1234);
    chk("alu_stall2", stall_o, 0);
    tick();
    chk("alu_valid_w", valid_w_o, 1);
    chk("alu_rd_w", rd_w_o, 5);
    chk("alu_res_w", alu_result_w_o, 32'h1234);
    chk("alu_rw_w", reg_write_w_o, 1);
    chk("alu_pc4_w", pc_plus_4w_o, 32'h44);

    // Load with immediate gnt and rvalid next cycle
    op_in(2'b01, 0, 1, 32'h100, 0, 5'd7);
    tick(); idle_in(); dmem_gnt_i = 1; #1;
    chk("ld_req", dmem_req_o, 1);
    chk("ld_addr", dmem_addr_o, 32'h100);
    chk("ld_we", dmem_we_o, 0);
    chk("ld_stall_req", stall_o, 1);
    chk("ld_fwd_we", fwd_reg_write_m_o, 0);
    tick(); dmem_gnt_i = 0;
    chk("ld_bubble", valid_w_o, 0);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEADBEEF; #1;
    chk("ld_stall_resp", stall_o, 0);
    chk("ld_req_resp", dmem_req_o, 0);
    tick(); dmem_rvalid_i = 0; dmem_rdata_i = 0;
    chk("ld_valid_w", valid_w_o, 1);
    chk("ld_rdata_w", read_data_w_o, 32'hDEADBEEF);
    chk("ld_src_w", result_src_w_o, 2'b01);
    chk("ld_rd_w", rd_w_o, 7);
    chk("ld_rw_w", reg_write_w_o, 1);
    #1 chk("ld_stall_after", stall_o, 0);

    // Store with gnt after 3 waiting cycles
    op_in(2'b00, 1, 1, 32'h204, 32'hCAFEF00D, 5'd2);
    tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_req", dmem_req_o, 1);
      chk("st_addr", dmem_addr_o, 32'h204);
      chk("st_wdata", dmem_wdata_o, 32'hCAFEF00D);
      chk("st_we", dmem_we_o, 1);
      chk("st_stall", stall_o, 1);
      tick();
      chk("st_bubble", valid_w_o, 0);
      chk("st_bubble_rw", reg_write_w_o, 0);
    end
    dmem_gnt_i = 1; #1;
    chk("st_req_gnt", dmem_req_o, 1);
    chk("st_addr_gnt", dmem_addr_o, 32'h204);
    chk("st_stall_gnt", stall_o, 0);
    tick(); dmem_gnt_i = 0; #1;
    chk("st_valid_w", valid_w_o, 1);
    chk("st_rw_w", reg_write_w_o, 0);
    chk("st_req_after", dmem_req_o, 0);
    chk("st_stall_after", stall_o, 0);

    // Flush while idle
    op_in(2'b00, 0, 1, 32'h55, 0, 5'd3); flush_i = 1;
    tick(); idle_in(); #1;
    chk("fl_fwd_we", fwd_reg_write_m_o, 0);
    tick();
    chk("fl_valid_w", valid_w_o, 0);

    // Flush during a pending load
    op_in(2'b01, 0, 1, 32'h300, 0, 5'd9);
    tick(); idle_in(); flush_i = 1; #1;
    chk("fld_stall1", stall_o, 1);
    tick(); dmem_gnt_i = 1; #1;
    chk("fld_req", dmem_req_o, 1);
    tick(); dmem_gnt_i = 0; #1;
    chk("fld_stall_resp", stall_o, 1);
    tick(); flush_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h12345678; #1;
    chk("fld_stall_rv", stall_o, 0);
    tick(); dmem_rvalid_i = 0; dmem_rdata_i = 0;
    chk("fld_valid_w", valid_w_o, 1);
    chk("fld_rdata_w", read_data_w_o, 32'h12345678);
    chk("fld_rd_w", rd_w_o, 9);

    // Reset while waiting for rvalid
    op_in(2'b01, 0, 1, 32'h400, 0, 5'd10);
    tick(); idle_in(); dmem_gnt_i = 1;
    tick(); dmem_gnt_i = 0; #1;
    chk("rr_stall_resp", stall_o, 1);
    rst_n = 0; #1;
    chk("rr_stall_rst", stall_o, 0);
    chk("rr_valid_rst", valid_w_o, 0);
    tick(); rst_n = 1; #1;
    chk("rr_stall_idle", stall_o, 0);
    chk("rr_req_idle", dmem_req_o, 0);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h0000_0BAD;
    tick(); dmem_rvalid_i = 0; dmem_rdata_i = 0;
    chk("rr_valid_w", valid_w_o, 0);
    chk("rr_rdata_w", read_data_w_o, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    op_in(2'b01, 0, 1, 32'h102, 0, 5'd4);
    tick(); idle_in(); #1;
    chk("mis_req", dmem_req_o, 0);
    chk("mis_stall", stall_o, 0);
    op_in(2'b01, 0, 1, 32'h106, 0, 5'd4);
    tick(); idle_in();
    chk("mis_flag", misalign_o, 1);
    chk("mis_addr", misalign_addr_o, 32'h102);
    chk("mis_valid_w", valid_w_o, 0);
    tick();
    chk("mis_addr_first", misalign_addr_o, 32'h102);
    chk("mis_valid_w2", valid_w_o, 0);
`else
    op_in(2'b01, 0, 1, 32'h102, 0, 5'd4);
    tick(); idle_in(); dmem_gnt_i = 1; #1;
    chk("mis_req", dmem_req_o, 1);
    chk("mis_addr", dmem_addr_o, 32'h100);
    tick(); dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h0BADF00D;
    tick(); dmem_rvalid_i = 0;
    chk("mis_valid_w", valid_w_o, 1);
    chk("mis_rdata_w", read_data_w_o, 32'h0BADF00D);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Memory stage of the 5-stage RV32 pipeline. Sits directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and runs word loads/stores over a req/gnt/rvalid data-memory handshake.
- Stalls the upstream stages while an access is in flight, then loads the MEM/WB register consumed by writeback.
- Exports MEM-slot forwarding info to the hazard unit.

Parameters:
D_WIDTH, 32, data/address width
REG_AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_e_i  in  1  execute slot holds a real instruction
reg_write_e_i  in  1  register write enable
result_src_e_i  in  2  00 ALU, 01 memory (load), 10 PC+4
mem_write_e_i  in  1  store
alu_result_e_i  in  D_WIDTH  ALU result / memory address
write_data_e_i  in  D_WIDTH  store data
rd_e_i  in  REG_AW  destination register
pc_plus_4e_i  in  D_WIDTH  PC+4
flush_i  in  1  insert bubble into EX/MEM
stall_o  out  1  hold fetch/decode/execute
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  D_WIDTH  word address, low 2 bits forced 0
dmem_wdata_o  out  D_WIDTH  store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  D_WIDTH  read data
fwd_reg_write_m_o  out  1  EX/MEM valid & reg_write & not load
fwd_rd_m_o  out  REG_AW  EX/MEM rd
fwd_alu_result_m_o  out  D_WIDTH  EX/MEM ALU result
valid_w_o, reg_write_w_o  out  1 each  MEM/WB control
result_src_w_o  out  2  MEM/WB result select
alu_result_w_o, read_data_w_o, pc_plus_4w_o  out  D_WIDTH each  MEM/WB data
rd_w_o  out  REG_AW  MEM/WB rd

Behaviour:
- Reset (async, rst_n low): FSM = IDLE. All valid bits and all registered outputs = 0. dmem_req_o = 0, stall_o = 0.
- EX/MEM capture: on each edge with stall_o = 0, capture the e-inputs.
  - Captured valid = valid_e_i & ~flush_i.
  - flush_i while stall_o = 1 is ignored; an in-flight access is never killed.
- Memory op: captured valid & (result_src = 01 or mem_write). The FSM leaves IDLE on the capture edge.
- FSM states:
  - IDLE: no access pending.
  - REQ: dmem_req_o = 1; addr/we/wdata come from the EX/MEM register and stay stable until gnt.
    - gnt with a store: go to IDLE.
    - gnt with a load: go to RESP.
    - no gnt: stay in REQ.
  - RESP: wait for dmem_rvalid_i. On rvalid, capture rdata into MEM/WB and go to IDLE.
- stall_o (combinational):
  - 1 in REQ, except a store's gnt cycle.
  - 1 in RESP without rvalid.
  - 0 otherwise.
- MEM/WB register: loads every edge.
  - Completing cycle (non-memory op, store gnt, or load rvalid): MEM/WB = EX/MEM contents plus read_data.
  - While stalled: valid_w_o = 0 (bubble), so writeback never writes twice.
- Latency:
  - Non-memory op: 1 cycle.
  - Load with gnt on the first REQ cycle and rvalid the next cycle: 2 cycles, stall_o high for exactly 1 cycle.
- Ignored inputs: rvalid outside RESP and gnt outside REQ are ignored.
- Reset mid-access: the outstanding access is abandoned; any later rvalid is ignored.
- Stores never write a register.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - A memory op with alu_result[1:0] != 0 issues no request; FSM stays IDLE.
  - The instruction goes to MEM/WB with valid_w_o = 0.
  - A sticky output misalign_o (1 bit) is set, plus misalign_addr_o (D_WIDTH) holding the first faulting address. Both are cleared only by reset.
- Undefined: misaligned addresses are issued with the low 2 bits forced to 0; the misalign ports do not exist.

Decomposition:
- Package riscv_pkg holds:
  - D_WIDTH and REG_AW defaults.
  - RES_ALU/RES_MEM/RES_PC4 encodings.
  - mem_state_t enum {IDLE, REQ, RESP}.
  - A struct for the EX/MEM payload.
- One sub-module, dmem_req_fsm: owns state, dmem_req_o, stall_o and the completion pulse.

Test Plan:
- ALU op, rd = 5, alu_result = 0x1234, no memory -> next edge valid_w_o = 1, rd_w_o = 5, alu_result_w_o = 0x1234; stall_o stays 0.
- Load addr 0x100, gnt in the same cycle, rvalid one cycle later with 0xDEADBEEF -> stall_o high 1 cycle; then valid_w_o = 1, read_data_w_o = 0xDEADBEEF, result_src_w_o = 01.
- Store addr 0x204 data 0xCAFEF00D, gnt delayed 3 cycles -> dmem_req_o held 3 cycles with stable addr/wdata; stall_o high 3 cycles; valid_w_o = 0 during the stall, reg_write_w_o = 0.
- flush_i with valid_e_i = 1 while idle -> valid_w_o = 0 next cycle. flush_i during a pending load -> load still completes with correct data.
- rst_n low while in RESP, rvalid arriving after release -> state IDLE, valid_w_o = 0, rvalid ignored.
- (MEM_MISALIGN_TRAP_EN) load addr 0x102 -> no dmem_req_o, misalign_o = 1, misalign_addr_o = 0x102, valid_w_o = 0.
